// File: rtl/ring_pkg.sv
// Shared types and helpers for one-hot ring counter consumers.
// Latency: n/a (package). Backpressure: n/a.
// Helpers operate on a MAX_W-bit container plus a run-time width so one
// definition serves every ring width up to MAX_W bits.
package ring_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } ring_state_t;

    // Mask selecting the low 'width' bits of the container.
    function automatic logic [MAX_W-1:0] ring_mask(input int width);
        logic [MAX_W-1:0] m;
        if (width >= MAX_W) begin
            m = '1;
        end else begin
            m = (MAX_W'(1) << width) - MAX_W'(1);
        end
        return m;
    endfunction

    // Rotate-left by one position within 'width' bits: {w[W-2:0], w[W-1]}.
    function automatic logic [MAX_W-1:0] ring_rotl(input logic [MAX_W-1:0] w,
                                                   input int width);
        logic [MAX_W-1:0] m;
        logic [MAX_W-1:0] wm;
        m  = ring_mask(width);
        wm = w & m;
        return ((wm << 1) | (wm >> (width - 1))) & m;
    endfunction

    // True when exactly one bit is set within the low 'width' bits.
    function automatic logic ring_is_onehot(input logic [MAX_W-1:0] w,
                                            input int width);
        logic [MAX_W-1:0] wm;
        wm = w & ring_mask(width);
        return (wm != '0) && ((wm & (wm - MAX_W'(1))) == '0);
    endfunction

    // Binary position of the set bit; OR-reduction so no priority chain
    // is built. Only meaningful for one-hot input.
    function automatic int ring_onehot_to_bin(input logic [MAX_W-1:0] w);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (w[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ring_onehot_decode.sv
// One-hot validity check and one-hot-to-binary conversion of a ring word.
// Latency: combinational. Backpressure: none.
// Ports: word (ring word in), is_onehot (exactly one bit set),
//        bin (position of the set bit, don't-care when not one-hot).
module ring_onehot_decode
    import ring_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] word,
    output logic             is_onehot,
    output logic [IDX_W-1:0] bin
);

    assign is_onehot = ring_is_onehot(MAX_W'(word), WIDTH);
    assign bin       = IDX_W'(ring_onehot_to_bin(MAX_W'(word)));

endmodule

// File: rtl/ring_decoder_monitor.sv
// Ring counter receiver: decodes the one-hot word and checks single-step rotation.
// Latency: all outputs registered, 1 cycle after the sample_en cycle.
// Backpressure: none; sample_en low freezes all state (source must stall too).
// Ports: clk, rst (sync, active-high), ring_in/sample_en (sample in),
//        clr_cnt (clear counters), index/index_valid (decoded position),
//        locked, err_pulse, err_count (saturating), rev_count (wrapping).
module ring_decoder_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 3,
    parameter int ERR_W  = 8,
    parameter int REV_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     sample_en,
    input  logic                     clr_cnt,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     index_valid,
    output logic                     locked,
    output logic                     err_pulse,
    output logic [ERR_W-1:0]         err_count,
    output logic [REV_W-1:0]         rev_count
);

    localparam int IDX_W  = $clog2(WIDTH);
    localparam int GOOD_W = $clog2(LOCK_N + 1);
    localparam int BAD_W  = $clog2(LOSS_N + 1);

    // Counter values at which the next step completes lock / drops lock.
    localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_N - 1);
    localparam logic [BAD_W-1:0]  LOSS_LAST = BAD_W'(LOSS_N - 1);

    ring_state_t       state;
    ring_state_t       state_nxt;
    logic [WIDTH-1:0]  expected;
    logic [WIDTH-1:0]  expected_nxt;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_nxt;
    logic [BAD_W-1:0]  bad_cnt;
    logic [BAD_W-1:0]  bad_nxt;
    logic              err_hit;
    logic              rev_hit;

    logic              onehot;
    logic [IDX_W-1:0]  dec_bin;
    logic              correct;
    logic [WIDTH-1:0]  rot_in;
    logic [WIDTH-1:0]  rot_exp;

    ring_onehot_decode #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decode (
        .word      (ring_in),
        .is_onehot (onehot),
        .bin       (dec_bin)
    );

    assign correct = onehot && (ring_in == expected);
    assign rot_in  = WIDTH'(ring_rotl(MAX_W'(ring_in), WIDTH));
    // Flywheel: on a bad sample the reference keeps rotating on its own
    // so a single glitch does not desynchronise a locked link.
    assign rot_exp = WIDTH'(ring_rotl(MAX_W'(expected), WIDTH));

    always_comb begin
        state_nxt    = state;
        expected_nxt = expected;
        good_nxt     = good_cnt;
        bad_nxt      = bad_cnt;
        err_hit      = 1'b0;
        rev_hit      = 1'b0;
        if (sample_en) begin
            case (state)
                ST_UNLOCKED: begin
                    if (onehot) begin
                        state_nxt    = ST_ACQUIRE;
                        expected_nxt = rot_in;
                        good_nxt     = '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (correct) begin
                        good_nxt     = good_cnt + GOOD_W'(1);
                        expected_nxt = rot_in;
                        if (good_cnt == LOCK_LAST) begin
                            state_nxt = ST_LOCKED;
                            bad_nxt   = '0;
                        end
                    end else if (onehot) begin
                        // Valid but out of sequence: reseed from this word.
                        expected_nxt = rot_in;
                        good_nxt     = '0;
                    end else begin
                        state_nxt = ST_UNLOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (correct) begin
                        bad_nxt      = '0;
                        expected_nxt = rot_in;
                        // Bit 0 set means the token just wrapped MSB->LSB.
                        rev_hit      = ring_in[0];
                    end else begin
                        err_hit      = 1'b1;
                        expected_nxt = rot_exp;
                        bad_nxt      = bad_cnt + BAD_W'(1);
                        if (bad_cnt == LOSS_LAST) begin
                            state_nxt = ST_UNLOCKED;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_UNLOCKED;
            expected    <= '0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            index       <= '0;
            index_valid <= 1'b0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
            rev_count   <= '0;
        end else begin
            state     <= state_nxt;
            expected  <= expected_nxt;
            good_cnt  <= good_nxt;
            bad_cnt   <= bad_nxt;
            locked    <= (state_nxt == ST_LOCKED);
            err_pulse <= err_hit;
            if (sample_en) begin
                index_valid <= onehot;
                if (onehot) begin
                    index <= dec_bin;
                end
            end
            // Clear wins over a same-cycle increment.
            if (clr_cnt) begin
                err_count <= '0;
            end else if (err_hit && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
            if (clr_cnt) begin
                rev_count <= '0;
            end else if (rev_hit) begin
                rev_count <= rev_count + REV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ring_decoder_monitor.sv
module tb_ring_decoder_monitor;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ring_in;
    logic       sample_en;
    logic       clr_cnt;

    logic [2:0]  index;
    logic        index_valid;
    logic        locked;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic [15:0] rev_count;

    logic [2:0]  index2;
    logic        index_valid2;
    logic        locked2;
    logic        err_pulse2;
    logic [1:0]  err_count2;
    logic [15:0] rev_count2;

    always #5 clk = ~clk;

    ring_decoder_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .ring_in     (ring_in),
        .sample_en   (sample_en),
        .clr_cnt     (clr_cnt),
        .index       (index),
        .index_valid (index_valid),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_count   (err_count),
        .rev_count   (rev_count)
    );

    // Same stimulus, 2-bit error counter to exercise saturation.
    ring_decoder_monitor #(.ERR_W(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .ring_in     (ring_in),
        .sample_en   (sample_en),
        .clr_cnt     (clr_cnt),
        .index       (index2),
        .index_valid (index_valid2),
        .locked      (locked2),
        .err_pulse   (err_pulse2),
        .err_count   (err_count2),
        .rev_count   (rev_count2)
    );

    typedef struct {
        int idx;
        int iv;
        int lck;
        int ep;
        int errc;
        int errc2;
        int rev;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_state = 0;  // 0 unlocked, 1 acquire, 2 locked
    logic [7:0] m_exp = 8'h00;
    int m_good = 0, m_bad = 0, m_idx = 0, m_iv = 0, m_ep = 0;
    int m_errc = 0, m_errc2 = 0, m_rev = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] w);
        return {w[6:0], w[7]};
    endfunction

    task automatic model_step(input logic [7:0] r, input logic en, input logic clr, input logic rs);
        bit   oh;
        bit   corr;
        bit   err_hit;
        bit   rev_hit;
        exp_t e;
        err_hit = 0;
        rev_hit = 0;
        if (rs) begin
            m_state = 0; m_exp = 8'h00; m_good = 0; m_bad = 0;
            m_idx = 0; m_iv = 0; m_ep = 0; m_errc = 0; m_errc2 = 0; m_rev = 0;
        end else begin
            m_ep = 0;
            if (en) begin
                oh   = ($countones(r) == 1);
                corr = oh && (r == m_exp);
                m_iv = oh ? 1 : 0;
                if (oh) begin
                    for (int i = 0; i < 8; i++) if (r[i]) m_idx = i;
                end
                case (m_state)
                    0: if (oh) begin m_state = 1; m_exp = rotl(r); m_good = 0; end
                    1: begin
                        if (corr) begin
                            m_good++;
                            m_exp = rotl(r);
                            if (m_good == LOCK_N) begin m_state = 2; m_bad = 0; end
                        end else if (oh) begin
                            m_exp = rotl(r); m_good = 0;
                        end else begin
                            m_state = 0;
                        end
                    end
                    default: begin
                        if (corr) begin
                            m_bad = 0; m_exp = rotl(r);
                            if (r[0]) rev_hit = 1;
                        end else begin
                            err_hit = 1; m_ep = 1;
                            m_exp = rotl(m_exp);
                            m_bad++;
                            if (m_bad == LOSS_N) m_state = 0;
                        end
                    end
                endcase
            end
            if (clr) begin
                m_errc = 0; m_errc2 = 0; m_rev = 0;
            end else begin
                if (err_hit && m_errc < 255) m_errc++;
                if (err_hit && m_errc2 < 3) m_errc2++;
                if (rev_hit) m_rev = (m_rev + 1) % 65536;
            end
        end
        e.idx = m_idx; e.iv = m_iv; e.lck = (m_state == 2) ? 1 : 0; e.ep = m_ep;
        e.errc = m_errc; e.errc2 = m_errc2; e.rev = m_rev;
        sb.push_back(e);
    endtask

    // Drive one cycle, predict, then compare the registered outputs #1 after the edge.
    task automatic drive(input logic [7:0] r, input logic en, input logic clr, input logic rs);
        exp_t e;
        rst = rs; ring_in = r; sample_en = en; clr_cnt = clr;
        model_step(r, en, clr, rs);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("index",       32'(index),       32'(e.idx));
            chk("index_valid", 32'(index_valid), 32'(e.iv));
            chk("locked",      32'(locked),      32'(e.lck));
            chk("err_pulse",   32'(err_pulse),   32'(e.ep));
            chk("err_count",   32'(err_count),   32'(e.errc));
            chk("rev_count",   32'(rev_count),   32'(e.rev));
            chk("err_count_w2", 32'(err_count2), 32'(e.errc2));
            chk("locked_w2",   32'(locked2),     32'(e.lck));
        end
    endtask

    logic [7:0] src;
    logic [7:0] rv;
    logic       en_r;

    initial begin
        rst = 1'b1; ring_in = 8'h00; sample_en = 1'b0; clr_cnt = 1'b0;
        @(negedge clk);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_errc",   32'(err_count), 32'd0);

        // Acquire: seed + 4 correct rotations
        src = 8'h01;
        for (int i = 0; i < 5; i++) begin
            drive(src, 1'b1, 1'b0, 1'b0);
            src = rotl(src);
        end
        chk("lock_after_5", 32'(locked), 32'd1);
        chk("lock_index",   32'(index), 32'd4);
        chk("lock_iv",      32'(index_valid), 32'd1);
        chk("lock_errc",    32'(err_count), 32'd0);

        // 16 more clean samples: two wraps through 0x01
        for (int i = 0; i < 16; i++) begin
            drive(src, 1'b1, 1'b0, 1'b0);
            src = rotl(src);
        end
        chk("rev_two", 32'(rev_count), 32'd2);

        // Expected 0x20; inject 0x40, then 0x40, 0x80
        drive(8'h40, 1'b1, 1'b0, 1'b0);
        chk("inj_pulse", 32'(err_pulse), 32'd1);
        chk("inj_errc",  32'(err_count), 32'd1);
        chk("inj_lock",  32'(locked), 32'd1);
        drive(8'h40, 1'b1, 1'b0, 1'b0);
        drive(8'h80, 1'b1, 1'b0, 1'b0);

        // Three all-zero samples drop lock
        for (int i = 0; i < 3; i++) drive(8'h00, 1'b1, 1'b0, 1'b0);
        chk("loss_lock", 32'(locked), 32'd0);
        chk("loss_iv",   32'(index_valid), 32'd0);
        chk("sat_w2",    32'(err_count2), 32'd3);

        // Relock, one more error, then error together with clr_cnt
        src = 8'h01;
        for (int i = 0; i < 5; i++) begin
            drive(src, 1'b1, 1'b0, 1'b0);
            src = rotl(src);
        end
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        chk("sat_w2_5", 32'(err_count2), 32'd3);
        drive(8'h00, 1'b1, 1'b1, 1'b0);
        chk("clr_errc",  32'(err_count), 32'd0);
        chk("clr_pulse", 32'(err_pulse), 32'd1);
        drive(8'h80, 1'b1, 1'b0, 1'b0);

        // sample_en gaps with source held
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        src = 8'h01;
        for (int i = 0; i < 8; i++) begin
            en_r = (i % 2 == 0) || (i >= 6);
            drive(src, en_r, 1'b0, 1'b0);
            if (en_r) src = rotl(src);
        end
        chk("gap_lock", 32'(locked), 32'd1);
        chk("gap_errc", 32'(err_count), 32'd0);

        // Reset during ACQUIRE
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        drive(8'h01, 1'b1, 1'b0, 1'b0);
        drive(8'h02, 1'b1, 1'b0, 1'b0);
        drive(8'h04, 1'b1, 1'b1, 1'b1);
        chk("mid_rst_idx", 32'(index), 32'd0);
        chk("mid_rst_iv",  32'(index_valid), 32'd0);

        // Random mix: mostly clean rotation with gaps, glitches and clears
        src = 8'h01;
        for (int i = 0; i < 300; i++) begin
            en_r = ($urandom_range(0, 4) != 0);
            rv = ($urandom_range(0, 11) == 0) ? 8'($urandom_range(0, 255)) : src;
            drive(rv, en_r, ($urandom_range(0, 29) == 0), 1'b0);
            if (en_r) src = rotl(src);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
